// File: rtl/alu_batch_driver.sv
// Batch ALU stimulus driver: latches up to DEPTH packed transactions and issues them one
// at a time over a start/done handshake. Define ALU_BATCH_TIMEOUT_EN for the WAIT watchdog.
module alu_batch_driver #(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 3,
  parameter int DEPTH       = 100,
  parameter int NOP_CODE    = 0,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       load_i,
  input  logic [DEPTH*3*DATA_W-1:0]  batch_i,
  input  logic [$clog2(DEPTH+1)-1:0] count_i,
  input  logic                       abort_i,
  output logic [DATA_W-1:0]          alu_a_o,
  output logic [DATA_W-1:0]          alu_b_o,
  output logic [OP_W-1:0]            alu_op_o,
  output logic                       alu_start_o,
  input  logic                       alu_done_i,
  input  logic [2*DATA_W-1:0]        alu_result_i,
  output logic [2*DATA_W-1:0]        res_o,
  output logic                       res_valid_o,
  output logic [$clog2(DEPTH)-1:0]   res_idx_o,
  output logic                       busy_o,
  output logic                       batch_done_o,
  output logic                       err_o
);
  localparam int SLOT_W  = 3 * DATA_W;
  localparam int BATCH_W = DEPTH * SLOT_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int BASE_W  = $clog2(BATCH_W);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_e;

  state_e              state_q;
  logic [BATCH_W-1:0]  batch_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    rem_q;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                start_q, res_valid_q, batch_done_q, done_pend_q;
  logic [2*DATA_W-1:0] res_q;
  logic [IDX_W-1:0]    res_idx_q;

  logic [BATCH_W-1:0]  src_d;
  logic [IDX_W-1:0]    sel_idx_d;
  logic [BASE_W-1:0]   base_d;
  logic [OP_W-1:0]     op_d;
  logic [DATA_W-1:0]   a_d, b_d;
  logic [CNT_W-1:0]    load_cnt_d;

`ifdef ALU_BATCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  // Fields of the slot issued next: slot 0 of the incoming batch on a load, else idx+1.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    src_d     = batch_q;
    sel_idx_d = idx_q + 1'b1;
    if (state_q == S_IDLE) begin
      src_d     = batch_i;
      sel_idx_d = '0;
    end
    base_d     = BASE_W'(sel_idx_d) * BASE_W'(SLOT_W);
    op_d       = src_d[base_d +: OP_W];
    a_d        = src_d[base_d + BASE_W'(DATA_W) +: DATA_W];
    b_d        = src_d[base_d + BASE_W'(2 * DATA_W) +: DATA_W];
    load_cnt_d = (count_i > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : count_i;
  end

  // NOTE: non-blocking assignments only, so every branch reads the pre-edge register values.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q      <= S_IDLE;
      // NOTE: the batch store is reset with the control state so a stale batch can never replay.
      batch_q      <= '0;
      idx_q        <= '0;
      rem_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      start_q      <= 1'b0;
      res_q        <= '0;
      res_idx_q    <= '0;
      res_valid_q  <= 1'b0;
      batch_done_q <= 1'b0;
      done_pend_q  <= 1'b0;
`ifdef ALU_BATCH_TIMEOUT_EN
      to_cnt_q     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      res_valid_q  <= 1'b0;
      batch_done_q <= done_pend_q;
      done_pend_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (load_i) begin
            batch_q <= batch_i;
            idx_q   <= '0;
            rem_q   <= load_cnt_d;
            if (load_cnt_d == '0) begin
              done_pend_q <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
              start_q <= 1'b1;
              op_q    <= op_d;
              a_q     <= a_d;
              b_q     <= b_d;
            end
          end
        end
        S_ISSUE: begin
          if (abort_i) begin
            start_q <= 1'b0;
            state_q <= S_IDLE;
          end else if (op_q == OP_W'(NOP_CODE)) begin
            start_q <= 1'b0;
            state_q <= S_GAP;
          end else begin
            state_q <= S_WAIT;
`ifdef ALU_BATCH_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (alu_done_i) begin
            res_q       <= alu_result_i;
            res_idx_q   <= idx_q;
            res_valid_q <= 1'b1;
            start_q     <= 1'b0;
            state_q     <= S_GAP;
          end
`ifdef ALU_BATCH_TIMEOUT_EN
          else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            err_q   <= 1'b1;
            start_q <= 1'b0;
            state_q <= S_GAP;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
          // A result captured on this edge is still reported; only the batch is dropped.
          if (abort_i) begin
            start_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_GAP: begin
          if (abort_i) begin
            state_q <= S_IDLE;
          end else if (rem_q == CNT_W'(1)) begin
            rem_q        <= '0;
            batch_done_q <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            rem_q   <= rem_q - 1'b1;
            start_q <= 1'b1;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            state_q <= S_ISSUE;
          end
        end
      endcase
    end
  end

  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_op_o     = op_q;
  assign alu_start_o  = start_q;
  assign res_o        = res_q;
  assign res_valid_o  = res_valid_q;
  assign res_idx_o    = res_idx_q;
  assign busy_o       = (state_q != S_IDLE);
  assign batch_done_o = batch_done_q;
`ifdef ALU_BATCH_TIMEOUT_EN
  assign err_o        = err_q;
`else
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_batch_driver.sv
// Self-checking bench for alu_batch_driver: directed scenarios plus random batches,
// results compared against a slot-list reference model and a behavioural tinyalu responder.
module tb_alu_batch_driver;
  localparam int DATA_W      = 8;
  localparam int OP_W        = 3;
  localparam int DEPTH       = 100;
  localparam int NOP_CODE    = 0;
  localparam int TIMEOUT_CYC = 8;
  localparam int SLOT_W      = 3 * DATA_W;
  localparam int CNT_W       = $clog2(DEPTH + 1);
  localparam int IDX_W       = $clog2(DEPTH);
  localparam int JUNK_W      = DATA_W - OP_W;

  logic                    clk_i = 1'b0;
  logic                    reset_i, load_i, abort_i, alu_done_i;
  logic [DEPTH*SLOT_W-1:0] batch_i;
  logic [CNT_W-1:0]        count_i;
  logic [2*DATA_W-1:0]     alu_result_i;
  logic [DATA_W-1:0]       alu_a_o, alu_b_o;
  logic [OP_W-1:0]         alu_op_o;
  logic                    alu_start_o, res_valid_o, busy_o, batch_done_o, err_o;
  logic [2*DATA_W-1:0]     res_o;
  logic [IDX_W-1:0]        res_idx_o;

  always #5 clk_i = ~clk_i;

  alu_batch_driver #(
    .DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH), .NOP_CODE(NOP_CODE), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .load_i(load_i), .batch_i(batch_i), .count_i(count_i),
    .abort_i(abort_i), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_start_o(alu_start_o), .alu_done_i(alu_done_i), .alu_result_i(alu_result_i),
    .res_o(res_o), .res_valid_o(res_valid_o), .res_idx_o(res_idx_o), .busy_o(busy_o),
    .batch_done_o(batch_done_o), .err_o(err_o)
  );

  typedef struct { int idx; logic [2*DATA_W-1:0] res; } res_t;
  typedef struct { int op; int len; } run_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference batch contents
  logic [OP_W-1:0]   m_op [DEPTH];
  logic [DATA_W-1:0] m_a  [DEPTH];
  logic [DATA_W-1:0] m_b  [DEPTH];

  // Monitor state
  res_t got_q [$];
  run_t runs  [$];
  int   n_done = 0;
  bit   busy_seen = 0;
  int   run_len = 0;
  int   run_op = 0;

  // ALU responder controls
  int alu_lat = 1;
  int hang_txn = -1;
  int alu_txn = 0;
  bit alu_pend = 0;
  bit alu_hang_now = 0;
  int alu_left = 0;

  function automatic logic [2*DATA_W-1:0] alu_ref(input logic [OP_W-1:0] op,
                                                  input logic [DATA_W-1:0] a, b);
    case (op)
      3'd1:    return (2*DATA_W)'(a) + (2*DATA_W)'(b);
      3'd2:    return (2*DATA_W)'(a & b);
      3'd3:    return (2*DATA_W)'(a ^ b);
      3'd4:    return (2*DATA_W)'(a) * (2*DATA_W)'(b);
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_slots(input bit allow_nop);
    for (int k = 0; k < DEPTH; k++) begin
      m_op[k] = allow_nop ? OP_W'($urandom_range(0, 4)) : OP_W'($urandom_range(1, 4));
      m_a[k]  = DATA_W'($urandom);
      m_b[k]  = DATA_W'($urandom);
    end
  endtask

  task automatic set_slot(input int k, input int op, input int a, input int b);
    m_op[k] = OP_W'(op);
    m_a[k]  = DATA_W'(a);
    m_b[k]  = DATA_W'(b);
  endtask

  task automatic pack_batch();
    logic [JUNK_W-1:0] junk;
    for (int k = 0; k < DEPTH; k++) begin
      junk = JUNK_W'($urandom);
      batch_i[k*SLOT_W +: SLOT_W] = {m_b[k], m_a[k], junk, m_op[k]};
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    runs.delete();
    n_done    = 0;
    busy_seen = 0;
  endtask

  task automatic do_load(input int cnt);
    count_i = CNT_W'(cnt);
    load_i  = 1'b1;
    @(negedge clk_i);
    load_i  = 1'b0;
  endtask

  task automatic wait_finish(input string tag, input int limit);
    int c = 0;
    while ((busy_o || n_done == 0) && c < limit) begin
      @(negedge clk_i);
      c++;
    end
    repeat (3) @(negedge clk_i);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_idle"}, busy_o, 0);
  endtask

  task automatic compare_results(input string tag, input int cnt, input int hang);
    res_t exp_q [$];
    res_t r;
    int lim = (cnt > DEPTH) ? DEPTH : cnt;
    for (int k = 0; k < lim; k++) begin
      if (m_op[k] != OP_W'(NOP_CODE) && k != hang) begin
        r.idx = k;
        r.res = alu_ref(m_op[k], m_a[k], m_b[k]);
        exp_q.push_back(r);
      end
    end
    check({tag, "_n_results"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_idx%0d", tag, i), got_q[i].idx, exp_q[i].idx);
      check($sformatf("%s_res%0d", tag, i), got_q[i].res, exp_q[i].res);
    end
  endtask

  // Behavioural tinyalu: done alu_lat cycles after a real start; done and result are
  // noise whenever the driver is not waiting on a real operation.
  initial begin
    alu_done_i   = 1'b0;
    alu_result_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      alu_done_i   = 1'b0;
      alu_result_i = (2*DATA_W)'($urandom);
      if (!alu_start_o || !reset_i || alu_op_o == OP_W'(NOP_CODE)) begin
        alu_pend   = 1'b0;
        alu_done_i = 1'($urandom_range(0, 1));
      end else if (!alu_pend) begin
        alu_pend     = 1'b1;
        alu_left     = alu_lat;
        alu_hang_now = (alu_txn == hang_txn);
        alu_txn++;
        alu_done_i   = 1'($urandom_range(0, 1));
      end else begin
        alu_left--;
        if (alu_left == 0 && !alu_hang_now) begin
          alu_done_i   = 1'b1;
          alu_result_i = alu_ref(alu_op_o, alu_a_o, alu_b_o);
        end
      end
    end
  end

  // Monitor: results, batch_done pulses and start-high run lengths
  initial begin
    res_t r;
    run_t rr;
    forever begin
      @(negedge clk_i);
      if (res_valid_o) begin
        r.idx = int'(res_idx_o);
        r.res = res_o;
        got_q.push_back(r);
      end
      if (batch_done_o) n_done++;
      if (busy_o) busy_seen = 1'b1;
      if (alu_start_o) begin
        run_len++;
        run_op = int'(alu_op_o);
      end else if (run_len > 0) begin
        rr.op  = run_op;
        rr.len = run_len;
        runs.push_back(rr);
        run_len = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int c;
    reset_i = 1'b0;
    load_i  = 1'b0;
    abort_i = 1'b0;
    batch_i = '0;
    count_i = '0;

    // Reset held low for 10 cycles
    repeat (10) @(negedge clk_i);
    check("reset_outputs", {res_o, res_valid_o, res_idx_o, busy_o, batch_done_o, alu_start_o,
                            alu_a_o, alu_b_o, alu_op_o, err_o}, '0);
    reset_i = 1'b1;
    @(negedge clk_i);

    // Directed three-slot batch, done one cycle after start
    fill_slots(1'b1);
    set_slot(0, 1, 3, 4);
    set_slot(1, 1, 255, 255);
    set_slot(2, 4, 10, 20);
    pack_batch();
    clear_mon();
    alu_lat = 1;
    do_load(3);
    check("t1_start_visible", {busy_o, alu_start_o, alu_op_o, alu_a_o, alu_b_o},
          {1'b1, 1'b1, 3'd1, 8'd3, 8'd4});
    wait_finish("t1", 100);
    compare_results("t1", 3, -1);
    check("t1_start_len", (runs.size() > 0) ? runs[0].len : 0, 2);

    // NOP slot: start high one cycle, no result
    fill_slots(1'b1);
    set_slot(0, NOP_CODE, $urandom, $urandom);
    set_slot(1, 1, 1, 2);
    pack_batch();
    clear_mon();
    do_load(2);
    wait_finish("t2", 100);
    compare_results("t2", 2, -1);
    check("t2_n_starts", runs.size(), 2);
    check("t2_nop_start_len", (runs.size() > 0) ? runs[0].len : 0, 1);

    // Oversized count saturates at DEPTH
    fill_slots(1'b1);
    pack_batch();
    clear_mon();
    alu_lat = $urandom_range(1, 3);
    do_load(DEPTH + 5);
    wait_finish("t3", 2000);
    compare_results("t3", DEPTH + 5, -1);
    check("t3_n_starts", runs.size(), DEPTH);

    // Random small batches
    for (int t = 0; t < 5; t++) begin
      fill_slots(1'b1);
      pack_batch();
      clear_mon();
      alu_lat = $urandom_range(1, 4);
      cnt = $urandom_range(1, 12);
      do_load(cnt);
      wait_finish($sformatf("rnd%0d", t), 400);
      compare_results($sformatf("rnd%0d", t), cnt, -1);
    end

    // Empty batch: batch_done after the following edge, no start
    clear_mon();
    count_i = '0;
    load_i  = 1'b1;
    @(negedge clk_i);
    load_i  = 1'b0;
    check("t5_done_not_yet", batch_done_o, 0);
    @(negedge clk_i);
    check("t5_done_pulse", batch_done_o, 1);
    @(negedge clk_i);
    check("t5_done_single", batch_done_o, 0);
    repeat (3) @(negedge clk_i);
    check("t5_never_busy", {busy_seen, 8'(runs.size())}, 0);

    // Abort while slot 2 of 5 is issuing
    fill_slots(1'b0);
    pack_batch();
    clear_mon();
    alu_lat = 3;
    do_load(5);
    c = 0;
    while (!(runs.size() == 2 && alu_start_o) && c < 200) begin
      @(negedge clk_i);
      c++;
    end
    check("t6_reached_slot2", c < 200, 1);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("t6_abort_stop", {alu_start_o, busy_o}, 0);
    repeat (10) @(negedge clk_i);
    check("t6_no_batch_done", n_done, 0);
    compare_results("t6", 2, -1);
    fill_slots(1'b1);
    pack_batch();
    clear_mon();
    do_load(3);
    wait_finish("t6b", 200);
    compare_results("t6b", 3, -1);

    // Simultaneous load and abort in IDLE: load wins
    fill_slots(1'b1);
    pack_batch();
    clear_mon();
    alu_lat = 2;
    count_i = CNT_W'(4);
    load_i  = 1'b1;
    abort_i = 1'b1;
    @(negedge clk_i);
    load_i  = 1'b0;
    abort_i = 1'b0;
    check("t7_load_taken", {busy_o, alu_start_o}, 2'b11);
    wait_finish("t7", 200);
    compare_results("t7", 4, -1);

    // Load during WAIT with different data is ignored
    fill_slots(1'b0);
    pack_batch();
    clear_mon();
    alu_lat = 4;
    do_load(4);
    @(negedge clk_i);
    for (int k = 0; k < DEPTH; k++) batch_i[k*SLOT_W +: SLOT_W] = SLOT_W'($urandom);
    count_i = CNT_W'(7);
    load_i  = 1'b1;
    @(negedge clk_i);
    load_i  = 1'b0;
    wait_finish("t8", 300);
    compare_results("t8", 4, -1);

    // Reset while waiting on the ALU
    fill_slots(1'b0);
    pack_batch();
    clear_mon();
    alu_lat = 6;
    do_load(3);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("t9_reset_outputs", {res_o, res_valid_o, res_idx_o, busy_o, batch_done_o, alu_start_o,
                               alu_a_o, alu_b_o, alu_op_o, err_o}, '0);
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    fill_slots(1'b1);
    pack_batch();
    clear_mon();
    alu_lat = 1;
    do_load(5);
    wait_finish("t9b", 200);
    compare_results("t9b", 5, -1);

`ifdef ALU_BATCH_TIMEOUT_EN
    // Watchdog: slot 1 never completes
    check("t10_err_before", err_o, 0);
    fill_slots(1'b0);
    pack_batch();
    clear_mon();
    alu_lat  = 1;
    alu_txn  = 0;
    hang_txn = 1;
    do_load(3);
    wait_finish("t10", 200);
    hang_txn = -1;
    compare_results("t10", 3, 1);
    check("t10_err_set", err_o, 1);
    check("t10_wait_len", (runs.size() > 1) ? runs[1].len : 0, TIMEOUT_CYC + 1);
`else
    check("err_tied_low", err_o, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
